// File: rtl/berger_scrub_memory.sv
// Berger-code protected single-port memory with fault injection and a background scrubber.
// Detect-only: mismatches are reported and counted, never corrected.
module berger_scrub_memory #(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 4,
    parameter int SCRUB_INTERVAL = 64,
    parameter int CNT_W          = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [DATA_W-1:0]                    input_data,
    input  logic [ADDR_W-1:0]                    input_addr,
    input  logic                                 wr_en,
    input  logic                                 rd_en,
    input  logic [DATA_W+$clog2(DATA_W+1)-1:0]   fault_mask,
    input  logic                                 fault_enable,
    input  logic                                 fault_store,
    input  logic                                 fault_zero_to_one,
    input  logic                                 scrub_enable,
    input  logic                                 clear_count,
    output logic [DATA_W-1:0]                    output_data,
    output logic                                 rd_valid,
    output logic                                 error_detected,
    output logic                                 scrub_busy,
    output logic                                 scrub_error,
    output logic [ADDR_W-1:0]                    scrub_err_addr,
    output logic [CNT_W-1:0]                     err_count
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CHK_W = $clog2(DATA_W + 1);
    localparam int CW_W  = DATA_W + CHK_W;
    localparam int IV_W  = $clog2(SCRUB_INTERVAL + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_CHECK} scrub_state_t;

    function automatic logic [CHK_W-1:0] zeros(input logic [DATA_W-1:0] d);
        logic [CHK_W-1:0] n;
        n = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (!d[i]) n = n + CHK_W'(1);
        end
        return n;
    endfunction

    logic [CW_W-1:0]   mem [DEPTH];
    logic [CW_W-1:0]   host_cw;
    logic [CW_W-1:0]   faulted_cw;
    logic [CW_W-1:0]   read_cw;
    logic [CW_W-1:0]   scrub_cw;
    logic [ADDR_W-1:0] ptr;
    logic [IV_W-1:0]   interval_cnt;
    logic              host_access;
    logic              host_mismatch;
    logic              scrub_mismatch;
    logic [CNT_W+1:0]  count_sum;
    logic [CNT_W-1:0]  count_next;
    scrub_state_t      state;

    assign host_cw       = mem[input_addr];
    assign faulted_cw    = fault_zero_to_one ? (host_cw | fault_mask) : (host_cw & ~fault_mask);
    assign read_cw       = fault_enable ? faulted_cw : host_cw;
    assign host_access   = wr_en | rd_en | fault_store;
    assign host_mismatch = rd_en && (zeros(read_cw[DATA_W-1:0]) != read_cw[CW_W-1:DATA_W]);
    // A disabled scrubber abandons its CHECK, so it must not report from it either.
    assign scrub_mismatch = (state == S_CHECK) && scrub_enable &&
                            (zeros(scrub_cw[DATA_W-1:0]) != scrub_cw[CW_W-1:DATA_W]);
    assign scrub_busy    = (state == S_READ) || (state == S_CHECK);

    assign count_sum  = {2'b00, err_count} + (CNT_W+2)'(host_mismatch) + (CNT_W+2)'(scrub_mismatch);
    assign count_next = (count_sum > {2'b00, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : count_sum[CNT_W-1:0];

    // Write beats a same-cycle fault_store; reads see the pre-edge contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= {CHK_W'(DATA_W), {DATA_W{1'b0}}};
            end
        end else if (wr_en) begin
            mem[input_addr] <= {zeros(input_data), input_data};
        end else if (fault_store) begin
            mem[input_addr] <= faulted_cw;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid       <= 1'b0;
            output_data    <= '0;
            error_detected <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                output_data    <= read_cw[DATA_W-1:0];
                error_detected <= host_mismatch;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_count) begin
            err_count <= '0;
        end else begin
            err_count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            ptr            <= '0;
            interval_cnt   <= '0;
            scrub_cw       <= '0;
            scrub_error    <= 1'b0;
            scrub_err_addr <= '0;
        end else begin
            scrub_error <= 1'b0;
            if (!scrub_enable) begin
                state <= S_IDLE;
                ptr   <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state        <= S_WAIT;
                        interval_cnt <= IV_W'(SCRUB_INTERVAL);
                    end
                    S_WAIT: begin
                        if (interval_cnt <= IV_W'(1)) begin
                            state <= S_READ;
                        end else begin
                            interval_cnt <= interval_cnt - IV_W'(1);
                        end
                    end
                    // Host traffic owns the array port; the scrubber simply retries.
                    S_READ: begin
                        if (!host_access) begin
                            scrub_cw <= mem[ptr];
                            state    <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (scrub_mismatch) begin
                            scrub_error    <= 1'b1;
                            scrub_err_addr <= ptr;
                        end
                        ptr <= ptr + ADDR_W'(1);
                        if (&ptr) begin
                            state        <= S_WAIT;
                            interval_cnt <= IV_W'(SCRUB_INTERVAL);
                        end else begin
                            state <= S_READ;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_berger_scrub_memory.sv
// Scoreboard bench for berger_scrub_memory: a reference memory model predicts every read,
// with a second CNT_W=2 instance sharing the stimulus to exercise counter saturation.
module tb_berger_scrub_memory;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  input_data;
    logic [3:0]  input_addr;
    logic        wr_en, rd_en;
    logic [11:0] fault_mask;
    logic        fault_enable, fault_store, fault_zero_to_one;
    logic        scrub_enable, clear_count;

    logic [7:0]  output_data, small_output_data;
    logic        rd_valid, small_rd_valid;
    logic        error_detected, small_error_detected;
    logic        scrub_busy, small_scrub_busy;
    logic        scrub_error, small_scrub_error;
    logic [3:0]  scrub_err_addr, small_scrub_err_addr;
    logic [7:0]  err_count;
    logic [1:0]  small_err_count;

    typedef struct packed {
        logic [7:0] data;
        logic       err;
    } exp_t;

    exp_t        exp_q [$];
    exp_t        exp_head;
    logic [11:0] model_mem [16];
    int          exp_count;
    int          exp_small;
    int          num_checks = 0;
    int          num_errors = 0;
    int          pulses;
    int          pulse_at;

    always #5 clk = ~clk;

    berger_scrub_memory #(.DATA_W(8), .ADDR_W(4), .SCRUB_INTERVAL(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .input_data(input_data), .input_addr(input_addr),
        .wr_en(wr_en), .rd_en(rd_en), .fault_mask(fault_mask), .fault_enable(fault_enable),
        .fault_store(fault_store), .fault_zero_to_one(fault_zero_to_one),
        .scrub_enable(scrub_enable), .clear_count(clear_count),
        .output_data(output_data), .rd_valid(rd_valid), .error_detected(error_detected),
        .scrub_busy(scrub_busy), .scrub_error(scrub_error), .scrub_err_addr(scrub_err_addr),
        .err_count(err_count)
    );

    berger_scrub_memory #(.DATA_W(8), .ADDR_W(4), .SCRUB_INTERVAL(4), .CNT_W(2)) small_dut (
        .clk(clk), .rst(rst), .input_data(input_data), .input_addr(input_addr),
        .wr_en(wr_en), .rd_en(rd_en), .fault_mask(fault_mask), .fault_enable(fault_enable),
        .fault_store(fault_store), .fault_zero_to_one(fault_zero_to_one),
        .scrub_enable(scrub_enable), .clear_count(clear_count),
        .output_data(small_output_data), .rd_valid(small_rd_valid),
        .error_detected(small_error_detected), .scrub_busy(small_scrub_busy),
        .scrub_error(small_scrub_error), .scrub_err_addr(small_scrub_err_addr),
        .err_count(small_err_count)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [3:0] count_zeros(input logic [7:0] d);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (d[i] == 1'b0) n++;
        end
        return 4'(n);
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 16; i++) model_mem[i] = 12'h800;
        exp_count = 0;
        exp_small = 0;
        exp_q.delete();
    endtask

    task automatic idle_inputs();
        wr_en = 0; rd_en = 0; fault_enable = 0; fault_store = 0; fault_zero_to_one = 0;
        clear_count = 0; input_addr = '0; input_data = '0; fault_mask = '0;
    endtask

    // One host cycle: predict, drive, step one edge, check the cycle-accurate outputs.
    task automatic applyStimulus(input logic wr, input logic rd, input logic fe, input logic fs,
                                 input logic z2o, input logic clr, input logic [3:0] addr,
                                 input logic [7:0] data, input logic [11:0] mask);
        logic [11:0] cw, fcw, rcw;
        logic        mis;
        cw  = model_mem[addr];
        fcw = z2o ? (cw | mask) : (cw & ~mask);
        rcw = fe ? fcw : cw;
        mis = rd && (count_zeros(rcw[7:0]) != rcw[11:8]);
        if (rd) exp_q.push_back({rcw[7:0], mis});
        if (clr) begin
            exp_count = 0;
            exp_small = 0;
        end else begin
            exp_count = (exp_count + int'(mis) > 255) ? 255 : exp_count + int'(mis);
            exp_small = (exp_small + int'(mis) > 3) ? 3 : exp_small + int'(mis);
        end
        if (wr) model_mem[addr] = {count_zeros(data), data};
        else if (fs) model_mem[addr] = fcw;

        wr_en = wr; rd_en = rd; fault_enable = fe; fault_store = fs; fault_zero_to_one = z2o;
        clear_count = clr; input_addr = addr; input_data = data; fault_mask = mask;
        @(posedge clk);
        #1;
        checkOutput("rd_valid", 32'(rd_valid), 32'(rd));
        checkOutput("err_count", 32'(err_count), 32'(exp_count));
        idle_inputs();
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_output_data"}, 32'(output_data), 0);
        checkOutput({tag, "_rd_valid"}, 32'(rd_valid), 0);
        checkOutput({tag, "_error_detected"}, 32'(error_detected), 0);
        checkOutput({tag, "_scrub_busy"}, 32'(scrub_busy), 0);
        checkOutput({tag, "_scrub_error"}, 32'(scrub_error), 0);
        checkOutput({tag, "_scrub_err_addr"}, 32'(scrub_err_addr), 0);
        checkOutput({tag, "_err_count"}, 32'(err_count), 0);
        checkOutput({tag, "_small_err_count"}, 32'(small_err_count), 0);
    endtask

    // Read results are popped from the scoreboard when the DUT presents them.
    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_rd_valid", 32'(rd_valid), 0);
            end else begin
                exp_head = exp_q.pop_front();
                checkOutput("output_data", 32'(output_data), 32'(exp_head.data));
                checkOutput("error_detected", 32'(error_detected), 32'(exp_head.err));
                checkOutput("small_output_data", 32'(small_output_data), 32'(exp_head.data));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1; scrub_enable = 0;
        idle_inputs();
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 0;

        // Host path: plain read, write, and both fault polarities on the read path.
        applyStimulus(0, 1, 0, 0, 0, 0, 4'd0, 8'h00, 12'h000);
        applyStimulus(1, 0, 0, 0, 0, 0, 4'd1, 8'hA5, 12'h000);
        applyStimulus(0, 1, 1, 0, 1, 0, 4'd1, 8'h00, 12'h001);
        applyStimulus(0, 1, 1, 0, 1, 0, 4'd1, 8'h00, 12'h002);
        applyStimulus(0, 1, 1, 0, 0, 0, 4'd1, 8'h00, 12'hF00);
        applyStimulus(0, 1, 1, 0, 0, 0, 4'd1, 8'h00, 12'h0FF);
        applyStimulus(0, 1, 0, 0, 0, 0, 4'd1, 8'h00, 12'h000);
        // Persistent fault, read-before-write, and write beating fault_store.
        applyStimulus(0, 0, 0, 1, 1, 0, 4'd3, 8'h00, 12'h010);
        applyStimulus(0, 1, 0, 0, 0, 0, 4'd3, 8'h00, 12'h000);
        applyStimulus(1, 1, 0, 0, 0, 0, 4'd5, 8'h3C, 12'h000);
        applyStimulus(0, 1, 0, 0, 0, 0, 4'd5, 8'h00, 12'h000);
        applyStimulus(1, 0, 0, 1, 0, 0, 4'd6, 8'hFF, 12'h0FF);
        applyStimulus(0, 1, 0, 0, 0, 0, 4'd6, 8'h00, 12'h000);
        applyStimulus(0, 0, 0, 0, 0, 1, 4'd0, 8'h00, 12'h000);
        checkOutput("small_err_count_cleared", 32'(small_err_count), 0);

        // Two full scrub passes; only address 3 carries a bad codeword.
        scrub_enable = 1;
        pulses = 0;
        for (int i = 1; i <= 72; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) checkOutput("scrub_busy_wait", 32'(scrub_busy), 0);
            if (i == 6) checkOutput("scrub_busy_check", 32'(scrub_busy), 1);
            if (scrub_error) begin
                pulses++;
                checkOutput("scrub_err_addr", 32'(scrub_err_addr), 3);
                checkOutput("scrub_pulse_cycle", i, (pulses == 1) ? 13 : 49);
                checkOutput("scrub_err_count", 32'(err_count), pulses);
            end
        end
        checkOutput("scrub_pulse_total", pulses, 2);
        exp_count = 2;

        scrub_enable = 0;
        applyStimulus(0, 0, 0, 0, 0, 1, 4'd0, 8'h00, 12'h000);
        checkOutput("scrub_idle_busy", 32'(scrub_busy), 0);

        // Host reads held continuously while the scrubber sits in READ.
        scrub_enable = 1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("stall_enter_busy", 32'(scrub_busy), 1);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 1, 0, 0, 0, 0, 4'd0, 8'h00, 12'h000);
            checkOutput("stall_busy", 32'(scrub_busy), 1);
            checkOutput("stall_no_scrub_error", 32'(scrub_error), 0);
        end
        pulse_at = 0;
        for (int i = 1; i <= 40 && pulse_at == 0; i++) begin
            @(posedge clk);
            #1;
            if (scrub_error) pulse_at = i;
        end
        checkOutput("release_pulse_cycle", pulse_at, 8);
        checkOutput("release_err_addr", 32'(scrub_err_addr), 3);
        checkOutput("release_err_count", 32'(err_count), 1);

        // Reset in the middle of a pass.
        repeat (3) @(posedge clk);
        rst = 1;
        @(posedge clk);
        #1;
        check_all_zero("midpass_reset");
        scrub_enable = 0;
        rst = 0;
        reset_model();
        applyStimulus(0, 1, 0, 0, 0, 0, 4'd3, 8'h00, 12'h000);
        applyStimulus(0, 1, 0, 0, 0, 0, 4'd5, 8'h00, 12'h000);

        // clear_count beats a faulty read, then the narrow counter saturates.
        applyStimulus(0, 1, 1, 0, 1, 1, 4'd1, 8'h00, 12'h001);
        checkOutput("clear_small_err_count", 32'(small_err_count), 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 1, 0, 1, 0, 4'd1, 8'h00, 12'h001);
            checkOutput("sat_small_err_count", 32'(small_err_count), 32'(exp_small));
        end

        repeat (2) @(posedge clk);
        #1;
        checkOutput("pending_reads", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end
endmodule
